// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU built from one full-adder slice, a 4:1 result select and a carry
// flop. It processes one operand bit per cycle, LSB first.
//
// Ops (op): 00 ADD, 01 SUB (a + ~b + 1), 10 AND, 11 OR.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, op are sampled in the accept cycle)
//   out_valid / out_ready  result handshake
//   result, carry        WIDTH-bit result; ADD carry-out, SUB no-borrow, 0 for AND/OR
//   zero, overflow       result==0 and signed overflow; present only with SERIAL_ALU_FLAGS_EN
//
// Optional build macro: SERIAL_ALU_FLAGS_EN adds the registered zero/overflow flags.
module serial_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpOr  = 2'b11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [1:0]         op_q, op_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               fa_sum, fa_cout;
  logic               out_bit;
  logic               arith;
  logic               last_bit;
  logic [WIDTH-1:0]   res_shift;

  // Single full-adder slice fed by the LSBs of the operand shift registers.
  assign fa_sum  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  assign arith    = ~op_q[1];
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // 4:1 result select, same encoding as op.
  always_comb begin
    out_bit = 1'b0;
    unique case (op_q)
      OpAdd, OpSub: out_bit = fa_sum;
      OpAnd:        out_bit = a_q[0] & b_q[0];
      OpOr:         out_bit = a_q[0] | b_q[0];
      default:      out_bit = 1'b0;
    endcase
  end

  // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign res_shift = {out_bit, res_q[WIDTH-1:1]};

`ifdef SERIAL_ALU_FLAGS_EN
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ALU_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (op == OpSub) ? ~b : b;
          op_d    = op;
          carry_d = (op == OpSub);
          cnt_d   = '0;
`ifdef SERIAL_ALU_FLAGS_EN
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
`endif
          state_d = StBusy;
        end
      end
      StBusy: begin
        res_d   = res_shift;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = arith ? fa_cout : 1'b0;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
`ifdef SERIAL_ALU_FLAGS_EN
          zero_d = (res_shift == '0);
          // Carry into the MSB is the flop value; carry out is this cycle's adder carry.
          ovf_d  = arith ? (carry_q ^ fa_cout) : 1'b0;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= OpAdd;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero     = zero_q;
  assign overflow = ovf_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed literal cases, backpressure, reset mid-op,
// back-to-back spacing and randomized traffic, all checked against a behavioural model.
module tb_serial_alu;

  localparam int unsigned W = 8;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpOr  = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b, result;
  logic [1:0]   op;
  logic         out_valid, out_ready, carry;
`ifdef SERIAL_ALU_FLAGS_EN
  logic         zero, overflow;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .op(op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .carry(carry)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .zero(zero),
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         ov;
  } exp_t;

  // Reference result straight from unsigned/signed arithmetic.
  function automatic exp_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [1:0] o);
    exp_t e;
    logic [W:0] s;
    e.c  = 1'b0;
    e.ov = 1'b0;
    case (o)
      OpAdd: begin
        s    = {1'b0, x} + {1'b0, y};
        e.r  = s[W-1:0];
        e.c  = s[W];
        e.ov = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      OpSub: begin
        e.r  = x - y;
        e.c  = (x >= y);
        e.ov = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      OpAnd:   e.r = x & y;
      default: e.r = x | y;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  exp_t q[$];
  int   mphase = 0;  // 0 waiting for operands, 1 computing, 2 result presented
  int   rem = 0;
  int   last_acc = -1;
  int   accepts = 0;
  bit   b2b_chk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mphase   = 0;
      q.delete();
      last_acc = -1;
    end else begin
      check("in_ready", 64'(in_ready), 64'(mphase == 0));
      check("out_valid", 64'(out_valid), 64'(mphase == 2));
      if (mphase == 2 && q.size() > 0) begin
        check("result", 64'(result), 64'(q[0].r));
        check("carry", 64'(carry), 64'(q[0].c));
`ifdef SERIAL_ALU_FLAGS_EN
        check("zero", 64'(zero), 64'(q[0].z));
        check("overflow", 64'(overflow), 64'(q[0].ov));
`endif
      end
      case (mphase)
        0: if (in_valid) begin
          q.push_back(ref_op(a, b, op));
          mphase = 1;
          rem    = W;
          if (b2b_chk && last_acc >= 0) check("accept_spacing", 64'(cyc - last_acc), 64'(W + 2));
          last_acc = cyc;
          accepts++;
        end
        1: begin
          rem--;
          if (rem == 0) mphase = 2;
        end
        default: if (out_ready) begin
          void'(q.pop_front());
          mphase = 0;
        end
      endcase
    end
  end

  // ---------------- directed helpers ----------------
  // Called at posedge+1. Waits for accept, measures latency, checks literal expectations.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o,
                        input logic [W-1:0] er, input logic ec, input logic ez, input logic eov,
                        input bit release_out);
    int n;
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    op        = o;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'(1), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    op       = 2'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(W));
    check("lit_result", 64'(result), 64'(er));
    check("lit_carry", 64'(carry), 64'(ec));
`ifdef SERIAL_ALU_FLAGS_EN
    check("lit_zero", 64'(zero), 64'(ez));
    check("lit_overflow", 64'(overflow), 64'(eov));
`else
    if (ez === 1'bx || eov === 1'bx) check("lit_flag_args", 64'(1), 64'(0));
`endif
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("idle_after_done", 64'(in_ready), 64'(1));
    end
  endtask

  initial begin
    int n;
    int acc0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = OpAdd;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_carry", 64'(carry), 64'(0));
`ifdef SERIAL_ALU_FLAGS_EN
    check("rst_zero", 64'(zero), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'hFF, 8'h01, OpAdd, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    run_op(8'h05, 8'h07, OpSub, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, OpSub, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b1);
    run_op(8'h7F, 8'h01, OpAdd, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op(8'hF0, 8'h3C, OpAnd, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(8'hF0, 8'h3C, OpOr,  8'hFC, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held, new operands presented but not accepted.
    run_op(8'h10, 8'h20, OpAdd, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    a        = 8'hAA;
    b        = 8'h55;
    op       = OpAdd;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_result", 64'(result), 64'(8'h30));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_after_hs", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_accepted", 64'(in_ready), 64'(0));
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_new_result", 64'(result), 64'(8'hFF));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset three cycles into BUSY.
    in_valid = 1'b1;
    a        = 8'h55;
    b        = 8'h11;
    op       = OpAdd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_carry", 64'(carry), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(8'h12, 8'h34, OpAdd, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back with both handshakes held high.
    last_acc  = -1;
    b2b_chk   = 1'b1;
    acc0      = accepts;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (6 * (W + 2) + 1) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 2'($urandom);
      @(posedge clk); #1;
    end
    check("b2b_accept_count", 64'(accepts - acc0), 64'(7));
    in_valid = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    b2b_chk = 1'b0;

    // Randomized traffic.
    acc0 = accepts;
    repeat (600) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      op        = 2'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 3) @(posedge clk);
    #1;
    check("random_made_progress", 64'(accepts - acc0 >= 20), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial arithmetic/logic unit built around the team's single-bit full-adder cell and 4:1 select primitive. It accepts two WIDTH-bit operands and a 2-bit opcode over a valid/ready handshake, then processes one bit per cycle, LSB first, through one full-adder slice and a carry flip-flop. It presents the result with carry-out over a second valid/ready handshake. It is the sequential datapath stage that drives the adder cells, trading latency for a single-slice area footprint.

## Interface
- WIDTH, 8: operand/result width; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR; same encoding as the 4:1 select inputs.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- carry  output  1  ADD: carry-out; SUB: no-borrow (1 when a >= b unsigned); AND/OR: 0.
- zero, overflow  output  1 each  present only with SERIAL_ALU_FLAGS_EN; see Configuration.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture a into shift register A, and capture b into shift register B, inverted when op=SUB.
  - Latch op.
  - Carry flop = 1 for SUB, else 0; bit counter = 0.
  - Go to BUSY.
- BUSY:
  - Each cycle, slice inputs are A[0], B[0], carry.
  - Output bit is selected by the latched op:
    - ADD/SUB: full-adder sum; carry flop <= full-adder carry.
    - AND: A[0]&B[0]; carry flop held at 0.
    - OR: A[0]|B[0]; carry flop held at 0.
  - The output bit shifts into result at the MSB end, with result shifting right. A and B shift right. The counter increments.
  - When counter == WIDTH-1, go to DONE after this cycle's bit.
- DONE:
  - out_valid=1; result and carry hold stable.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. a, b and op only need to be stable in the accept cycle.
- Unsigned WIDTH-bit arithmetic, modulo 2^WIDTH.
- SUB is computed as a + ~b + 1.

## Timing
- Reset (asynchronous, any state, including mid-BUSY): state IDLE, in_ready=1, out_valid=0, result=0, carry=0, zero=0, overflow=0, counter=0. Any in-flight operation is discarded.
- Latency: handshake at edge T0; out_valid rises after edge T0+WIDTH.
- Minimum op period is WIDTH+2 cycles with out_ready held high: accept cycle, WIDTH BUSY cycles, 1 DONE cycle.
- in_ready and out_valid are registered-state decodes and are never high simultaneously.
- in_ready does not depend combinationally on out_ready.
- Backpressure: DONE persists indefinitely while out_ready=0; outputs do not change.
- out_ready asserted outside DONE has no effect.

## Configuration
- SERIAL_ALU_FLAGS_EN defined:
  - zero = (result == 0).
  - overflow = signed overflow for ADD/SUB, computed as carry into MSB XOR carry out of MSB in the final BUSY cycle; 0 for AND/OR.
  - Both flags are registered, valid with out_valid, and cleared on reset.
- SERIAL_ALU_FLAGS_EN undefined: zero and overflow ports and their logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01 -> result=0x00, carry=1, zero=1, overflow=0; out_valid exactly 8 cycles after accept.
- SUB a=0x05 b=0x07 -> result=0xFE, carry=0, overflow=0. SUB a=0x80 b=0x01 -> result=0x7F, carry=1, overflow=1.
- ADD a=0x7F b=0x01 -> result=0x80, carry=0, overflow=1. AND a=0xF0 b=0x3C -> 0x30, carry=0. OR on the same operands -> 0xFC.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands presented -> result stable, in_ready=0, new op not accepted until 1 cycle after the out_ready handshake.
- Reset mid-op: assert rst_n=0 for 1 cycle, 3 cycles into BUSY -> immediately out_valid=0, result=0, in_ready=1. A following ADD 0x12+0x34 -> 0x46.
- Back-to-back ops with out_ready=1 and in_valid=1: successive accepts are exactly WIDTH+2=10 cycles apart, with results in order.
